// File: rtl/neuron_seq_mac.sv
// Time-multiplexed neuron: one sign-magnitude MAC per cycle into P/N accumulators, |P-N| out.
// Optional macro NEURON_SEQ_SAT_EN: P/N clamp at all-ones and report sat; otherwise they wrap.
module neuron_seq_mac #(
  parameter int N_INPUTS   = 60,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 22,
  parameter int PROD_SHIFT = 15,
  localparam int ADDR_W    = $clog2(N_INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_we,
  input  logic [ADDR_W-1:0]            w_addr,
  input  logic [DATA_W-1:0]            w_data,
  input  logic                         start,
  input  logic [N_INPUTS*DATA_W-1:0]   uzorak,
  output logic                         busy,
  output logic                         done,
  output logic [ACC_W-1:0]             suma,
  output logic                         predznak,
  output logic                         sat
);

  localparam int MAG_W  = DATA_W - 1;
  localparam int PROD_W = MAG_W + DATA_W;
  localparam int EXT_W  = (PROD_W > ACC_W) ? PROD_W : ACC_W;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_CMP} state_t;

  state_t                                state_q, state_d;
  logic [ADDR_W-1:0]                     idx_q, idx_d;
  logic [N_INPUTS*DATA_W-1:0]            uzorak_q, uzorak_d;
  logic [ACC_W-1:0]                      p_q, p_d, n_q, n_d;
  logic [ACC_W-1:0]                      suma_q, suma_d;
  logic                                  predznak_q, predznak_d;
  logic                                  done_q, done_d;
  logic [N_INPUTS-1:0][DATA_W-1:0]       w_q, w_d;

  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] samp_cur;
  logic [PROD_W-1:0] prod_full;
  logic [EXT_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  prod;
  logic [ACC_W-1:0]  acc_sel;
  logic [ACC_W-1:0]  acc_add;
  logic              acc_ovf;

  // Weight file: writes only land while the datapath is idle.
  always_comb begin
    w_d = w_q;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (w_we && (state_q == S_IDLE) && (int'(w_addr) == i)) begin
        w_d[i] = w_data;
      end
    end
  end

  always_comb begin
    w_cur     = w_q[idx_q];
    samp_cur  = uzorak_q[idx_q*DATA_W +: DATA_W];
    prod_full = PROD_W'(w_cur[MAG_W-1:0]) * PROD_W'(samp_cur);
    prod_ext  = EXT_W'(prod_full) >> PROD_SHIFT;
    prod      = prod_ext[ACC_W-1:0];
    acc_sel   = w_cur[DATA_W-1] ? n_q : p_q;
`ifdef NEURON_SEQ_SAT_EN
    {acc_ovf, acc_add} = {1'b0, acc_sel} + {1'b0, prod};
    if (acc_ovf) begin
      acc_add = '1;
    end
`else
    acc_ovf = 1'b0;
    acc_add = acc_sel + prod;
`endif
  end

`ifdef NEURON_SEQ_SAT_EN
  logic sat_q, sat_d;
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    uzorak_d   = uzorak_q;
    p_d        = p_q;
    n_d        = n_q;
    suma_d     = suma_q;
    predznak_d = predznak_q;
    done_d     = 1'b0;
`ifdef NEURON_SEQ_SAT_EN
    sat_d      = sat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          uzorak_d = uzorak;
          p_d      = '0;
          n_d      = '0;
          idx_d    = '0;
`ifdef NEURON_SEQ_SAT_EN
          sat_d    = 1'b0;
`endif
          state_d  = S_MAC;
        end
      end
      S_MAC: begin
        if (w_cur[DATA_W-1]) begin
          n_d = acc_add;
        end else begin
          p_d = acc_add;
        end
`ifdef NEURON_SEQ_SAT_EN
        sat_d = sat_q | acc_ovf;
`endif
        if (idx_q == ADDR_W'(N_INPUTS - 1)) begin
          state_d = S_CMP;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_CMP: begin
        // A tie reports as negative zero, matching the activation LUT's expectation.
        if (p_q > n_q) begin
          suma_d     = p_q - n_q;
          predznak_d = 1'b0;
        end else begin
          suma_d     = n_q - p_q;
          predznak_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      uzorak_q   <= '0;
      p_q        <= '0;
      n_q        <= '0;
      suma_q     <= '0;
      predznak_q <= 1'b0;
      done_q     <= 1'b0;
      w_q        <= '0;
`ifdef NEURON_SEQ_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      uzorak_q   <= uzorak_d;
      p_q        <= p_d;
      n_q        <= n_d;
      suma_q     <= suma_d;
      predznak_q <= predznak_d;
      done_q     <= done_d;
      w_q        <= w_d;
`ifdef NEURON_SEQ_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign suma     = suma_q;
  assign predznak = predznak_q;

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Scoreboard bench for neuron_seq_mac: stimulus pushes expected results, a monitor checks each done.
// Expected saturation results depend on NEURON_SEQ_SAT_EN.
module tb_neuron_seq_mac;
  localparam int N  = 5;   // one spare input so that w_addr = N is representable
  localparam int DW = 16;
  localparam int AW = 17;
  localparam int ADW = $clog2(N);

  logic              clk;
  logic              rst;
  logic              w_we;
  logic [ADW-1:0]    w_addr;
  logic [DW-1:0]     w_data;
  logic              start;
  logic [N*DW-1:0]   uzorak;
  logic              busy;
  logic              done;
  logic [AW-1:0]     suma;
  logic              predznak;
  logic              sat;

  typedef struct {
    logic [AW-1:0] suma;
    logic          pred;
    logic          sat;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;

  neuron_seq_mac #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW), .PROD_SHIFT(15)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .start(start), .uzorak(uzorak), .busy(busy), .done(done),
    .suma(suma), .predznak(predznak), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("result %0d [%s]: suma=0x%0h predznak=%0b sat=%0b", n_done, e.name, suma, predznak, sat);
        chk({e.name, " suma"}, 32'(suma), 32'(e.suma));
        chk({e.name, " predznak"}, 32'(predznak), 32'(e.pred));
        chk({e.name, " sat"}, 32'(sat), 32'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic set_samples(input logic [DW-1:0] s0, s1, s2, s3, s4);
    uzorak = {s4, s3, s2, s1, s0};
  endtask

  task automatic write_w(input logic [ADW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  // Runs one evaluation, checking busy and done each cycle up to the done cycle.
  // chained: start was already accepted at the previous edge (held from the prior run).
  // hold: keep start high until the done cycle so the next run begins back-to-back.
  // wr0/wr_busy: issue a write together with start, or during cycle 2 of MAC.
  task automatic run_eval(input string name, input bit chained, input bit hold,
                          input bit wr0, input bit wr_busy,
                          input logic [ADW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [AW-1:0] es, input logic ep, input logic esat);
    exp_t e;
    if (!chained) begin
      @(negedge clk);
      start = 1'b1;
      if (wr0) begin
        w_we = 1'b1; w_addr = wa; w_data = wd;
      end
    end
    e.suma = es; e.pred = ep; e.sat = esat; e.name = name;
    exp_q.push_back(e);
    for (int cyc = 1; cyc <= N + 2; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        if (!hold) start = 1'b0;
        w_we = 1'b0;
      end
      if (wr_busy && cyc == 2) begin
        w_we = 1'b1; w_addr = wa; w_data = wd;
      end
      if (wr_busy && cyc == 3) w_we = 1'b0;
      chk($sformatf("%s busy c%0d", name, cyc), 32'(busy), 32'(cyc <= N + 1));
      chk($sformatf("%s done c%0d", name, cyc), 32'(done), 32'(cyc == N + 2));
    end
  endtask

  initial begin
    logic [AW-1:0] sat_suma;
    logic          sat_flag;
    rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0; start = 1'b0; uzorak = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset suma", 32'(suma), 0);
    chk("reset predznak", 32'(predznak), 0);
    chk("reset sat", 32'(sat), 0);

    // P = 0x4000 + 0x2000, N = 0x4000; the spare input has weight 0.
    write_w(0, 16'h4000);
    write_w(1, 16'hC000);
    write_w(2, 16'h2000);
    write_w(3, 16'h0000);
    write_w(4, 16'h0000);
    set_samples(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF);
    run_eval("basic", 0, 0, 0, 0, '0, '0, 17'h02000, 1'b0, 1'b0);

    set_samples(16'h0000, 16'h8000, 16'h0000, 16'h0000, 16'hFFFF);
    run_eval("neg", 0, 0, 0, 0, '0, '0, 17'h04000, 1'b1, 1'b0);

    // Out-of-range addresses must not disturb any weight.
    write_w(3'd5, 16'h7FFF);
    write_w(3'd7, 16'h7FFF);
    run_eval("oob_addr", 0, 0, 0, 0, '0, '0, 17'h04000, 1'b1, 1'b0);

    // Write during busy is dropped; start held through busy is ignored, then restarts at done.
    set_samples(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'hFFFF);
    run_eval("busy_wr", 0, 1, 0, 1, 3'd0, 16'h7FFF, 17'h02000, 1'b0, 1'b0);
    run_eval("b2b", 1, 0, 0, 0, '0, '0, 17'h02000, 1'b0, 1'b0);

    // Write with start in the same idle cycle: w2 becomes -0x2000, so N = 0x6000, P = 0x4000.
    run_eval("wr_start", 0, 0, 1, 0, 3'd2, 16'hA000, 17'h02000, 1'b1, 1'b0);

    // Four products of 0xFFFD overflow 17 bits.
`ifdef NEURON_SEQ_SAT_EN
    sat_suma = 17'h1FFFF; sat_flag = 1'b1;
`else
    sat_suma = 17'h1FFF4; sat_flag = 1'b0;
`endif
    for (int i = 0; i < 4; i++) write_w(ADW'(i), 16'h7FFF);
    set_samples(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_eval("overflow", 0, 0, 0, 0, '0, '0, sat_suma, 1'b0, sat_flag);

    // Reset in cycle 2 of an evaluation aborts it and clears the weights.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset busy", 32'(busy), 0);
    chk("midreset suma", 32'(suma), 0);
    chk("midreset predznak", 32'(predznak), 0);
    chk("midreset sat", 32'(sat), 0);
    chk("midreset done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < N + 3; c++) begin
      @(negedge clk);
      chk($sformatf("aborted done c%0d", c), 32'(done), 0);
    end
    run_eval("zero_w", 0, 0, 0, 0, '0, '0, 17'h00000, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    chk("scoreboard empty", 32'(exp_q.size()), 0);
    chk("done count", 32'(n_done), 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
